// File: rtl/msft_riscv_mem_pkg.sv
// Shared types and helpers for the banked tightly-coupled memory.
package msft_riscv_mem_pkg;

  // Widest supported word: 32 data bits plus one capability tag bit.
  localparam int MAX_DW  = 33;
  // Position of the capability tag inside a 33-bit word.
  localparam int TAG_BIT = 32;

  // One requestor's command, decoded from the flattened port buses.
  typedef struct packed {
    logic [31:0]       addr;
    logic              we;
    logic [3:0]        be;
    logic [MAX_DW-1:0] wdata;
  } mem_req_t;

  // One requestor's response, before packing onto the output buses.
  typedef struct packed {
    logic [MAX_DW-1:0] rdata;
    logic              err;
  } mem_rsp_t;

  // A capability survives only a full-word write; any partial write,
  // including one with no byte enables at all, invalidates it.
  function automatic logic tag_merge(input logic [3:0] be, input logic wdata_tag);
    return (be == 4'hF) ? wdata_tag : 1'b0;
  endfunction

endpackage

// File: rtl/msftDvIp_fpga_block_ram_byte_wr_model.sv
// Single-port block RAM with per-byte write strobes and a registered read
// port. Strobe lane k covers bits [8k +: 8], clipped to DATA_WIDTH, so a
// 33-bit word has a fifth lane holding only the tag bit.
module msftDvIp_fpga_block_ram_byte_wr_model #(
  parameter int DATA_WIDTH = 33,
  parameter int DEPTH      = 8192,
  localparam int AW        = $clog2(DEPTH),
  localparam int NUM_LANES = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [NUM_LANES-1:0]  wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Strobed write or registered read; the read register holds otherwise.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int j = 0; j < DATA_WIDTH; j++) begin
          if (wstrb[j / 8]) begin
            mem[addr][j] <= wdata[j];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/msft_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at ptr, winner+1 becomes
// the new ptr. The pointer only moves when something is granted.
module msft_rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_nxt;
  logic          found;
  logic [PW-1:0] win;

  function automatic int wrap(input int v);
    return (v >= N) ? (v - N) : v;
  endfunction

  // Pick the first requester at or after ptr_q, wrapping around.
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    win     = '0;
    ptr_nxt = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!found && req[wrap(int'(ptr_q) + i)]) begin
        found = 1'b1;
        win   = PW'(wrap(int'(ptr_q) + i));
      end
    end
    if (en && found) begin
      gnt[win] = 1'b1;
      ptr_nxt  = PW'(wrap(int'(win) + 1));
    end
  end

  // Pointer register; holds while the bank is idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_nxt;
    end
  end

endmodule

// File: rtl/msft_riscv_banked_mem_v1.sv
// Multi-port tightly-coupled memory: NUM_PORTS requestors share NUM_BANKS
// word-interleaved single-port banks, each with its own round-robin arbiter.
//
// Handshake (every port): the requestor raises req_i with addr/we/be/wdata
// and holds them stable until gnt_o is seen high. gnt_o is combinational and
// the access happens in that same cycle. Exactly one cycle later rvalid_o
// pulses for one cycle with err_o and rdata_o (rdata_o is zero unless it is
// a successful read). Grants in consecutive cycles yield rvalids in
// consecutive cycles; there is no backpressure on the response side.
module msft_riscv_banked_mem_v1
  import msft_riscv_mem_pkg::*;
#(
  parameter int          DATA_WIDTH = 33,
  parameter int          NUM_PORTS  = 3,
  parameter int          NUM_BANKS  = 2,
  parameter int          BANK_DEPTH = 'h2000,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS*32-1:0]         addr_i,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*4-1:0]          be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_PORTS-1:0]            err_o
);

  localparam int LB        = $clog2(NUM_BANKS);
  localparam int LD        = $clog2(BANK_DEPTH);
  localparam int BSW       = (NUM_BANKS > 1) ? LB : 1;
  localparam int NUM_LANES = (DATA_WIDTH + 7) / 8;
  // Region size in bytes; 33 bits so a full 4 GiB region still compares.
  localparam logic [32:0] REGION_BYTES =
    33'(longint'(NUM_BANKS) * longint'(BANK_DEPTH) * 64'd4);

  mem_req_t              preq      [NUM_PORTS];
  logic [31:0]           off       [NUM_PORTS];
  logic [NUM_PORTS-1:0]  in_range;
  logic [BSW-1:0]        bank_sel  [NUM_PORTS];
  logic [LD-1:0]         word_idx  [NUM_PORTS];

  logic [NUM_PORTS-1:0]  bank_req  [NUM_BANKS];
  logic [NUM_PORTS-1:0]  gnt_bank  [NUM_BANKS];
  logic [NUM_PORTS-1:0]  gnt_any;
  logic [DATA_WIDTH-1:0] ram_rdata [NUM_BANKS];

  logic [NUM_PORTS-1:0]  rsp_valid;
  logic [NUM_PORTS-1:0]  rsp_err;
  logic [NUM_PORTS-1:0]  rsp_rd;
  logic [BSW-1:0]        rsp_bank  [NUM_PORTS];
  mem_rsp_t              prsp      [NUM_PORTS];

  // Unpack port buses and decode offset into range / bank / word index.
  // An address below BASE_ADDR wraps to a huge offset and lands out of range.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      preq[p].addr  = addr_i[p*32 +: 32];
      preq[p].we    = we_i[p];
      preq[p].be    = be_i[p*4 +: 4];
      preq[p].wdata = MAX_DW'(wdata_i[p*DATA_WIDTH +: DATA_WIDTH]);
      off[p]        = preq[p].addr - BASE_ADDR;
      in_range[p]   = ({1'b0, off[p]} < REGION_BYTES);
      bank_sel[p]   = BSW'((off[p] >> 2) & 32'(NUM_BANKS - 1));
      word_idx[p]   = LD'(off[p] >> (2 + LB));
    end
  end

  // Route each in-range request to the arbiter of the bank it targets.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        bank_req[b][p] = req_i[p] & in_range[p] & (bank_sel[p] == BSW'(b));
      end
    end
  end

  // Out-of-range requests bypass arbitration; nothing is granted in reset.
  always_comb begin
    gnt_any = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      gnt_any = gnt_any | gnt_bank[b];
    end
    gnt_o = {NUM_PORTS{rstn_i}} & req_i & (~in_range | gnt_any);
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                  sel_en;
    logic                  sel_we;
    logic [LD-1:0]         sel_addr;
    logic [3:0]            sel_be;
    logic [MAX_DW-1:0]     sel_wdata;
    logic [NUM_LANES-1:0]  ram_wstrb;
    logic [DATA_WIDTH-1:0] ram_wdata;

    msft_rr_arbiter #(
      .N (NUM_PORTS)
    ) u_arb (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .en    (rstn_i),
      .req   (bank_req[b]),
      .gnt   (gnt_bank[b])
    );

    // Steer the single granted port's command onto this bank.
    always_comb begin
      sel_en    = 1'b0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_be    = '0;
      sel_wdata = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (gnt_bank[b][p]) begin
          sel_en    = 1'b1;
          sel_we    = preq[p].we;
          sel_addr  = word_idx[p];
          sel_be    = preq[p].be;
          sel_wdata = preq[p].wdata;
        end
      end
    end

    if (DATA_WIDTH > 32) begin : g_tag
      // The tag lane is written on every write; its value is the merged tag.
      assign ram_wstrb = {sel_we, sel_be};
      assign ram_wdata = {tag_merge(sel_be, sel_wdata[TAG_BIT]), sel_wdata[31:0]};
    end else begin : g_plain
      assign ram_wstrb = sel_be;
      assign ram_wdata = sel_wdata[DATA_WIDTH-1:0];
    end

    msftDvIp_fpga_block_ram_byte_wr_model #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BANK_DEPTH)
    ) u_ram (
      .clk   (clk_i),
      .en    (sel_en),
      .we    (sel_we),
      .addr  (sel_addr),
      .wstrb (ram_wstrb),
      .wdata (ram_wdata),
      .rdata (ram_rdata[b])
    );
  end

  // Response pipe: remember what was granted so next cycle's mux knows
  // which bank register to forward. Reset drops anything in flight.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_rd    <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_bank[p] <= '0;
      end
    end else begin
      rsp_valid <= gnt_o;
      rsp_err   <= ~in_range;
      rsp_rd    <= ~we_i;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rsp_bank[p] <= bank_sel[p];
      end
    end
  end

  // Build responses; data is forced to zero unless this is a good read.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      prsp[p] = '0;
      if (rsp_valid[p]) begin
        prsp[p].err = rsp_err[p];
        if (!rsp_err[p] && rsp_rd[p]) begin
          prsp[p].rdata = MAX_DW'(ram_rdata[rsp_bank[p]]);
        end
      end
      rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = prsp[p].rdata[DATA_WIDTH-1:0];
      err_o[p]                            = prsp[p].err;
    end
    rvalid_o = rsp_valid;
  end

endmodule

// File: tb/tb_msft_riscv_banked_mem_v1.sv
// Directed bench for the banked memory with default parameters
// (33-bit words, 3 ports, 2 banks of 8192 words, base 0).
module tb_msft_riscv_banked_mem_v1;

  localparam int NP = 3;
  localparam int DW = 33;
  localparam int W  = DW + 1;

  logic            clk;
  logic            rstn;
  logic [NP-1:0]   req_i;
  logic [NP*32-1:0] addr_i;
  logic [NP-1:0]   we_i;
  logic [NP*4-1:0] be_i;
  logic [NP*DW-1:0] wdata_i;
  logic [NP-1:0]   gnt_o;
  logic [NP-1:0]   rvalid_o;
  logic [NP*DW-1:0] rdata_o;
  logic [NP-1:0]   err_o;

  logic            tb_req   [NP];
  logic [31:0]     tb_addr  [NP];
  logic            tb_we    [NP];
  logic [3:0]      tb_be    [NP];
  logic [DW-1:0]   tb_wdata [NP];

  logic [W-1:0]    exp_q [NP][$];
  logic [W-1:0]    exp_e;

  int n_checks;
  int n_pass;

  msft_riscv_banked_mem_v1 dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .req_i    (req_i),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o)
  );

  for (genvar p = 0; p < NP; p++) begin : g_pin
    assign req_i[p]            = tb_req[p];
    assign addr_i[p*32 +: 32]  = tb_addr[p];
    assign we_i[p]             = tb_we[p];
    assign be_i[p*4 +: 4]      = tb_be[p];
    assign wdata_i[p*DW +: DW] = tb_wdata[p];
  end

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver: present a request, wait for its grant, queue the expected response.
  task automatic access(input int p, input logic [31:0] a, input logic we,
                        input logic [3:0] be, input logic [DW-1:0] wd,
                        input logic exp_err, input logic [DW-1:0] exp_rd,
                        input int exp_wait);
    int waited;
    waited      = 0;
    tb_addr[p]  = a;
    tb_we[p]    = we;
    tb_be[p]    = be;
    tb_wdata[p] = wd;
    tb_req[p]   = 1'b1;
    @(negedge clk);
    while (!gnt_o[p]) begin
      waited++;
      if (waited >= 20) begin
        check($sformatf("p%0d_gnt_timeout", p), 64'd0, 64'd1);
        tb_req[p] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    exp_q[p].push_back({exp_err, exp_rd});
    check($sformatf("p%0d_gnt_wait@%0h", p, a), 64'(waited), 64'(exp_wait));
    @(posedge clk);
    #1;
    tb_req[p] = 1'b0;
  endtask

  // Monitor: every rvalid pops one expected response; idle rdata must be 0.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (rvalid_o[p]) begin
        if (exp_q[p].size() == 0) begin
          check($sformatf("p%0d_unexpected_rvalid", p), 64'd1, 64'd0);
        end else begin
          exp_e = exp_q[p].pop_front();
          check($sformatf("p%0d_rsp", p), 64'({err_o[p], rdata_o[p*DW +: DW]}), 64'(exp_e));
        end
      end else begin
        check($sformatf("p%0d_idle_rdata", p), 64'(rdata_o[p*DW +: DW]), 64'd0);
      end
    end
  end

  initial begin
    #400000;
    check("global_timeout", 64'd0, 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int p = 0; p < NP; p++) begin
      tb_req[p] = 1'b0; tb_addr[p] = '0; tb_we[p] = 1'b0;
      tb_be[p] = '0; tb_wdata[p] = '0;
    end
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_err",    64'(err_o),    64'd0);
    check("rst_gnt",    64'(gnt_o),    64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Full-word write keeps the tag, then read it back.
    access(0, 32'h0, 1'b1, 4'hF, 33'h1_DEADBEEF, 1'b0, 33'h0, 0);
    access(0, 32'h0, 1'b0, 4'hF, 33'h0,          1'b0, 33'h1_DEADBEEF, 0);

    // Byte write merges data and clears the tag.
    access(1, 32'h0, 1'b1, 4'h1, 33'h0_000000AA, 1'b0, 33'h0, 0);
    access(1, 32'h0, 1'b0, 4'hF, 33'h0,          1'b0, 33'h0_DEADBEAA, 0);

    // Different banks in the same cycle are both granted.
    access(1, 32'h4, 1'b1, 4'hF, 33'h0_12345678, 1'b0, 33'h0, 0);
    fork
      access(0, 32'h0, 1'b0, 4'hF, 33'h0, 1'b0, 33'h0_DEADBEAA, 0);
      access(1, 32'h4, 1'b0, 4'hF, 33'h0, 1'b0, 33'h0_12345678, 0);
    join

    // Three-way contest on one bank: P0, P1, P2 in order.
    access(2, 32'h8, 1'b1, 4'hF, 33'h1_CAFEF00D, 1'b0, 33'h0, 0);
    fork
      access(0, 32'h8, 1'b0, 4'hF, 33'h0, 1'b0, 33'h1_CAFEF00D, 0);
      access(1, 32'h8, 1'b0, 4'hF, 33'h0, 1'b0, 33'h1_CAFEF00D, 1);
      access(2, 32'h8, 1'b0, 4'hF, 33'h0, 1'b0, 33'h1_CAFEF00D, 2);
    join
    // Pointer wrapped back to P0, so P0 beats P1.
    fork
      access(1, 32'h8, 1'b0, 4'hF, 33'h0, 1'b0, 33'h1_CAFEF00D, 1);
      access(0, 32'h8, 1'b0, 4'hF, 33'h0, 1'b0, 33'h1_CAFEF00D, 0);
    join

    // Write with no byte enables: data kept, tag cleared.
    access(0, 32'h8, 1'b1, 4'h0, 33'h1_FFFFFFFF, 1'b0, 33'h0, 0);
    access(0, 32'h8, 1'b0, 4'hF, 33'h0,          1'b0, 33'h0_CAFEF00D, 0);

    // Last word of the region is in range.
    access(0, 32'hFFFC, 1'b1, 4'hF, 33'h1_55AA55AA, 1'b0, 33'h0, 0);
    access(0, 32'hFFFC, 1'b0, 4'hF, 33'h0,          1'b0, 33'h1_55AA55AA, 0);

    // Out of range: immediate grant, error response, no RAM effect.
    access(2, 32'h10000, 1'b0, 4'hF, 33'h0, 1'b1, 33'h0, 0);
    fork
      access(0, 32'h10000, 1'b0, 4'hF, 33'h0, 1'b1, 33'h0, 0);
      access(1, 32'h0,     1'b0, 4'hF, 33'h0, 1'b0, 33'h0_DEADBEAA, 0);
    join
    access(2, 32'h10000, 1'b1, 4'hF, 33'h1_11111111, 1'b1, 33'h0, 0);
    access(0, 32'h3,     1'b0, 4'hF, 33'h0, 1'b0, 33'h0_DEADBEAA, 0);

    // Reset with a read just granted; bank 1 pointer then sits at P2.
    access(1, 32'h4, 1'b0, 4'hF, 33'h0, 1'b0, 33'h0_12345678, 0);
    rstn        = 1'b0;
    tb_addr[0]  = 32'h4;
    tb_we[0]    = 1'b0;
    tb_be[0]    = 4'hF;
    tb_req[0]   = 1'b1;
    @(negedge clk);
    check("rst_hold_gnt0", 64'(gnt_o), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_gnt",    64'(gnt_o),    64'd0);
      check("rst_hold_rvalid", 64'(rvalid_o), 64'd0);
      check("rst_hold_err",    64'(err_o),    64'd0);
    end
    @(posedge clk); #1;
    rstn      = 1'b1;
    tb_req[0] = 1'b0;
    fork
      access(2, 32'h4, 1'b0, 4'hF, 33'h0, 1'b0, 33'h0_12345678, 2);
      access(1, 32'h4, 1'b0, 4'hF, 33'h0, 1'b0, 33'h0_12345678, 1);
      access(0, 32'h4, 1'b0, 4'hF, 33'h0, 1'b0, 33'h0_12345678, 0);
    join

    repeat (3) @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("p%0d_q_drained", p), 64'(exp_q[p].size()), 64'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
